// File: rtl/reg_file32_pkg.sv
// reg_file32_pkg: shared widths, sizes and well-known register numbers for the MIPS register file
package reg_file32_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_file32_if.sv
// reg_file32_if: read, write and debug signals between the pipeline (master) and the register file (slave)
interface reg_file32_if;
  import reg_file32_pkg::*;
  reg_addr_t rd_addr0;
  reg_addr_t rd_addr1;
  reg_data_t rd_data0;
  reg_data_t rd_data1;
  logic      wr_en;
  reg_addr_t wr_addr;
  reg_data_t wr_data;
  reg_addr_t dbg_addr;
  reg_data_t dbg_data;
  modport master (
    output rd_addr0, rd_addr1, wr_en, wr_addr, wr_data, dbg_addr,
    input  rd_data0, rd_data1, dbg_data
  );
  modport slave (
    input  rd_addr0, rd_addr1, wr_en, wr_addr, wr_data, dbg_addr,
    output rd_data0, rd_data1, dbg_data
  );
endinterface

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port with zero-register forcing; optional WB bypass under REG_FILE_WRITE_BYPASS_EN
module reg_file_rd_port
  import reg_file32_pkg::*;
#(
  parameter int WIDTH = REG_DATA_W,
  parameter int DEPTH = NUM_REGS
) (
  input  logic                        reset,
  input  reg_addr_t                   addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic                        wr_en,
  input  reg_addr_t                   wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            data
);
`ifdef REG_FILE_WRITE_BYPASS_EN
  // write-before-read: a same-cycle WB write to this address is seen immediately; r0 always reads 0
  always_comb
    data = (addr == REG_ZERO) ? '0 :
           (!reset && wr_en && wr_addr == addr) ? wr_data : regs[addr];
`else
  logic unused_wr;
  assign unused_wr = ^{reset, wr_en, wr_addr, wr_data};
  // stored value only; r0 always reads 0
  always_comb
    data = (addr == REG_ZERO) ? '0 : regs[addr];
`endif
endmodule

// File: rtl/reg_file32.sv
// reg_file32: 32x32 MIPS GPR file, two read ports (rs/rt), one WB write port, one debug read port; REG_FILE_WRITE_BYPASS_EN enables WB->ID bypass
module reg_file32
  import reg_file32_pkg::*;
#(
  parameter int WIDTH = REG_DATA_W,
  parameter int DEPTH = NUM_REGS
) (
  input logic         clk,
  input logic         reset,
  reg_file32_if.slave bus
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  // async clear; writes to r0 are dropped and nothing is captured while wr_en is low
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= '0;
    else if (bus.wr_en && bus.wr_addr != REG_ZERO) regs[bus.wr_addr] <= bus.wr_data;
  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rs (
    .reset(reset), .addr(bus.rd_addr0), .regs(regs),
    .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .data(bus.rd_data0)
  );
  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rt (
    .reset(reset), .addr(bus.rd_addr1), .regs(regs),
    .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .data(bus.rd_data1)
  );
  // debug port reads storage directly; r0 is never written so it stays 0
  always_comb bus.dbg_data = regs[bus.dbg_addr];
endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32: table-driven and hand-sequenced self-checking bench for reg_file32 with an expectation queue
module tb_reg_file32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  reg_file32_if bus();
  reg_file32 dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a0, a1, ad;
    logic [31:0] e0, e1, ed;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] act);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected <none>", act);
    end else begin
      e = q.pop_front();
      check(e.name, act, e.v);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] ad);
    bus.wr_en = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr0 = a0;
    bus.rd_addr1 = a1;
    bus.dbg_addr = ad;
  endtask

  task automatic write(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    set_in(1'b1, wa, wd, bus.rd_addr0, bus.rd_addr1, bus.dbg_addr);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 5'd1,  32'h11111111, 5'd2,  5'd3,  5'd1,  32'h0,        32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd2,  32'h22222222, 5'd1,  5'd1,  5'd1,  32'h11111111, 32'h11111111, 32'h11111111};
    tbl[2] = '{1'b0, 5'd1,  32'hFFFFFFFF, 5'd2,  5'd1,  5'd2,  32'h22222222, 32'h11111111, 32'h22222222};
    tbl[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd1,  5'd2,  5'd0,  32'h11111111, 32'h22222222, 32'h0};
    tbl[4] = '{1'b1, 5'd0,  32'hCAFEF00D, 5'd31, 5'd0,  5'd31, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    tbl[5] = '{1'b1, 5'd1,  32'h00000001, 5'd0,  5'd31, 5'd1,  32'h0,        32'hA5A5A5A5, 32'h11111111};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  5'd0,  32'h00000001, 32'h22222222, 32'h0};
    tbl[7] = '{1'b1, 5'd2,  32'h33333333, 5'd1,  5'd31, 5'd2,  32'h00000001, 32'hA5A5A5A5, 32'h22222222};
    tbl[8] = '{1'b0, 5'd2,  32'h0,        5'd2,  5'd2,  5'd2,  32'h33333333, 32'h33333333, 32'h33333333};

    set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd17);
    #3;
    check("reset_rd0", bus.rd_data0, 32'h0);
    check("reset_rd1", bus.rd_data1, 32'h0);
    check("reset_dbg", bus.dbg_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    write(5'd5, 32'hDEADBEEF);
    bus.rd_addr0 = 5'd5;
    #1 check("preload_r5", bus.rd_data0, 32'hDEADBEEF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_r5", bus.rd_data0, 32'h0);
    #1 reset = 1'b0;
    #1 check("reset_release_midcycle", bus.rd_data0, 32'h0);
    @(posedge clk);
    #1 check("after_reset_edge_r5", bus.rd_data0, 32'h0);

    write(5'd8, 32'h0000000C);
    write(5'd9, 32'hFFFFFFFF);
    bus.rd_addr0 = 5'd8;
    bus.rd_addr1 = 5'd9;
    bus.dbg_addr = 5'd9;
    #1;
    check("basic_r8", bus.rd_data0, 32'h0000000C);
    check("basic_r9", bus.rd_data1, 32'hFFFFFFFF);
    check("basic_dbg_r9", bus.dbg_data, 32'hFFFFFFFF);

    @(negedge clk);
    set_in(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 5'd0);
    #1;
    check("zero_same_cycle_rd0", bus.rd_data0, 32'h0);
    check("zero_same_cycle_rd1", bus.rd_data1, 32'h0);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    check("zero_after_rd0", bus.rd_data0, 32'h0);
    check("zero_after_rd1", bus.rd_data1, 32'h0);
    check("zero_after_dbg", bus.dbg_data, 32'h0);

    write(5'd10, 32'd7);
    @(negedge clk);
    set_in(1'b1, 5'd10, 32'd99, 5'd10, 5'd9, 5'd10);
    #1;
    check("rw_same_cycle_rd0", bus.rd_data0, BYP ? 32'd99 : 32'd7);
    check("rw_same_cycle_dbg", bus.dbg_data, 32'd7);
    check("rw_same_cycle_other", bus.rd_data1, 32'hFFFFFFFF);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    check("rw_after_rd0", bus.rd_data0, 32'd99);
    check("rw_after_dbg", bus.dbg_data, 32'd99);

    @(negedge clk);
    set_in(1'b0, 5'd3, 32'h55, 5'd3, 5'd3, 5'd3);
    repeat (3) @(posedge clk);
    #1;
    check("wren_low_rd0", bus.rd_data0, 32'h0);
    check("wren_low_dbg", bus.dbg_data, 32'h0);

    @(negedge clk);
    set_in(1'b1, 5'd4, 32'hAA, 5'd4, 5'd10, 5'd4);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_vs_write_rd0", bus.rd_data0, 32'h0);
    check("reset_vs_write_dbg", bus.dbg_data, 32'h0);
    check("reset_vs_write_r10", bus.rd_data1, 32'h0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1, tbl[i].ad);
      push($sformatf("vec%0d_rd0", i), tbl[i].e0);
      push($sformatf("vec%0d_rd1", i), tbl[i].e1);
      push($sformatf("vec%0d_dbg", i), tbl[i].ed);
      #1;
      pop_check(bus.rd_data0);
      pop_check(bus.rd_data1);
      pop_check(bus.dbg_data);
      @(posedge clk);
    end
    #1 bus.wr_en = 1'b0;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file32.md
Name: reg_file32

Overview:
- 32-entry x 32-bit MIPS general-purpose register file for the pipelined CPU.
- Sits in ID, directly upstream of the 32-bit operand muxes (ALUSrc / forwarding selects): rd_data0/rd_data1 feed the mux in0 inputs.
- Writes come from the WB stage.
- A third read-only debug port drives the board display logic.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; address width is log2(DEPTH) = 5.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- rd_addr0  in  5  read port 0 address (rs).
- rd_addr1  in  5  read port 1 address (rt).
- rd_data0  out  WIDTH  read port 0 data.
- rd_data1  out  WIDTH  read port 1 data.
- wr_en  in  1  write enable from WB (RegWrite).
- wr_addr  in  5  write address.
- wr_data  in  WIDTH  write data.
- dbg_addr  in  5  debug read address.
- dbg_data  out  WIDTH  debug read data; never bypassed.

Behaviour:
- Storage: DEPTH x WIDTH flops.
- Reset:
  - While reset is high, all entries are 0 immediately, independent of clk.
  - Consequently rd_data0, rd_data1 and dbg_data read 0 for any address.
  - Deasserting reset mid-cycle does nothing until the next rising edge.
- Write:
  - On the rising edge with wr_en=1, reset=0 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - Write latency is 1 cycle; the value is visible on the non-bypassed paths after the edge.
- Register 0:
  - Hardwired to 0; writes to address 0 are silently dropped.
  - Any read of address 0 returns 0 on every port, including the bypass path.
- Read:
  - Fully combinational, zero latency: rd_dataN = reg[rd_addrN].
  - Both read ports may carry the same address; both return the same value.
- Simultaneous read/write of the same nonzero address in one cycle:
  - Without bypass: the read returns the old value until the edge.
  - With bypass: see Optional Feature.
- Write with wr_en=0: no state change, regardless of wr_addr and wr_data.
- X-safety: wr_addr and wr_data are don't-care when wr_en=0; the storage must not capture X from them.
- Reset has priority over a write on the same edge.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined:
  - If wr_en=1, wr_addr!=0 and wr_addr==rd_addrN, then rd_dataN = wr_data combinationally in the same cycle (write-before-read).
  - This removes the WB->ID hazard.
  - The bypass is suppressed while reset is high.
  - dbg_data is never bypassed.
- Undefined: no bypass. The pipeline relies on split-cycle timing or forwarding instead; reads return stored values only.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5
  - REG_DATA_W = 32
  - NUM_REGS = 32
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31 (used by the jal path)
- Sub-module reg_file_rd_port: one address in, storage plus write-side signals in, data out.
  - Contains the zero-register check and the ifdef'd bypass compare.
  - Instantiated twice (rs and rt).
  - dbg_data uses a plain index without the sub-module.

Test Plan:
- Async reset: preload reg 5=0xDEADBEEF; pulse reset between clock edges -> rd_data0 (addr 5) goes to 0 before the next edge.
- Basic write/read: write reg 8=12, reg 9=0xFFFFFFFF on consecutive edges; read addr0=8, addr1=9 -> 0x0000000C, 0xFFFFFFFF; dbg_addr=9 -> 0xFFFFFFFF.
- Zero register:
  - Write 0x1234 to addr 0 -> reads of addr 0 on all three ports stay 0.
  - With the macro defined, a same-cycle read of addr 0 stays 0.
- Same-cycle read/write: reg 10=7; set wr_addr=10, wr_data=99, wr_en=1, rd_addr0=10.
  - Before the edge, without the macro -> 7; with the macro -> 99.
  - After the edge -> 99 in both builds.
- wr_en low: wr_addr=3, wr_data=0x55, wr_en=0 over 3 edges -> reg 3 unchanged (0 after reset).
- Reset vs write: assert reset while wr_en=1 (addr 4, data 0xAA) across an edge -> reg 4 reads 0 after reset releases.
